// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Divider support is compiled in only when PIPE_CTRL_DIV_EN is defined.
package pipeline_ctrl_pkg;

  localparam int DIV_CYCLES_DEFAULT = 33;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One bit per pipeline-register control, in output-port order.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_exe_stall;
    logic id_exe_flush;
    logic exe_mem_stall;
    logic exe_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  localparam ctrl_t CTRL_FLUSH_ALL = '{
    pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
    id_exe_stall: 1'b0, id_exe_flush: 1'b1,
    exe_mem_stall: 1'b0, exe_mem_flush: 1'b1, mem_wb_flush: 1'b1
  };

  localparam ctrl_t CTRL_DMEM = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
    id_exe_stall: 1'b1, id_exe_flush: 1'b0,
    exe_mem_stall: 1'b1, exe_mem_flush: 1'b0, mem_wb_flush: 1'b1
  };

  localparam ctrl_t CTRL_DIV = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
    id_exe_stall: 1'b1, id_exe_flush: 1'b0,
    exe_mem_stall: 1'b0, exe_mem_flush: 1'b1, mem_wb_flush: 1'b0
  };

  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
    id_exe_stall: 1'b0, id_exe_flush: 1'b1,
    exe_mem_stall: 1'b0, exe_mem_flush: 1'b0, mem_wb_flush: 1'b0
  };

  localparam ctrl_t CTRL_IMEM = '{
    pc_stall: 1'b1, if_id_stall: 1'b0, if_id_flush: 1'b1,
    id_exe_stall: 1'b0, id_exe_flush: 1'b0,
    exe_mem_stall: 1'b0, exe_mem_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // Counter width for a given busy length; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_div_timer.sv
// Divider sequencing FSM and busy down-counter (module div_timer).
// Instantiated by pipeline_ctrl only when PIPE_CTRL_DIV_EN is defined.
module div_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic exe_is_div,
  input  logic exc_valid,
  input  logic dmem_stall,
  output logic div_start,
  output logic div_busy
);

  localparam int CW = cnt_width(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  div_state_e state, state_next;
  logic [CW-1:0] count, count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    div_start  = 1'b0;
    div_busy   = 1'b0;

    case (state)
      RUN: begin
        div_busy = exe_is_div;
        if (exe_is_div && !exc_valid) begin
          div_start  = 1'b1;
          count_next = CNT_LOAD;
          state_next = DIV_WAIT;
        end
      end
      // The count keeps running under a data-memory stall.
      DIV_WAIT: begin
        div_busy = 1'b1;
        if (count == '0) begin
          state_next = DIV_DONE;
        end else begin
          count_next = count - CW'(1);
        end
      end
      DIV_DONE: begin
        if (!dmem_stall) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        count_next = '0;
      end
    endcase

    // A committed exception aborts any divide in progress.
    if (exc_valid) begin
      state_next = RUN;
      count_next = '0;
    end

    if (rst) begin
      div_start = 1'b0;
      div_busy  = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with fixed-priority hazard resolution.
// Define PIPE_CTRL_DIV_EN to include the multi-cycle divider interlock.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exe_is_div,
  input  logic       exe_load_wreg,
  input  logic [4:0] exe_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       imem_stall,
  input  logic       dmem_stall,
  input  logic       exc_valid,
  output logic       PC_Stall,
  output logic       IF_ID_Stall,
  output logic       IF_ID_Flush,
  output logic       ID_EXE_Stall,
  output logic       ID_EXE_Flush,
  output logic       EXE_MEM_Stall,
  output logic       EXE_MEM_Flush,
  output logic       MEM_WB_Flush,
  output logic       div_start,
  output logic       div_busy
);

  logic  load_use;
  ctrl_t ctrl;

`ifdef PIPE_CTRL_DIV_EN
  div_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_timer (
    .clk       (clk),
    .rst       (rst),
    .exe_is_div(exe_is_div),
    .exc_valid (exc_valid),
    .dmem_stall(dmem_stall),
    .div_start (div_start),
    .div_busy  (div_busy)
  );
`else
  logic unused_div_inputs;

  assign unused_div_inputs = exe_is_div ^ (DIV_CYCLES < 1);
  assign div_start         = 1'b0;
  assign div_busy          = 1'b0;
`endif

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = exe_load_wreg && (exe_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == exe_rd)) ||
                     (id_use_rt && (id_rt == exe_rd)));

  // Reset drives the same response as an exception: flush everything.
  always_comb begin
    ctrl = CTRL_NONE;
    if (rst || exc_valid) begin
      ctrl = CTRL_FLUSH_ALL;
    end else if (dmem_stall) begin
      ctrl = CTRL_DMEM;
    end else if (div_busy) begin
      ctrl = CTRL_DIV;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end else if (imem_stall) begin
      ctrl = CTRL_IMEM;
    end
  end

  assign PC_Stall      = ctrl.pc_stall;
  assign IF_ID_Stall   = ctrl.if_id_stall;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EXE_Stall  = ctrl.id_exe_stall;
  assign ID_EXE_Flush  = ctrl.id_exe_flush;
  assign EXE_MEM_Stall = ctrl.exe_mem_stall;
  assign EXE_MEM_Flush = ctrl.exe_mem_flush;
  assign MEM_WB_Flush  = ctrl.mem_wb_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl; divider steps run only
// when PIPE_CTRL_DIV_EN is defined.
module tb_pipeline_ctrl;

  localparam int DIV_N = 33;

  // Expected output vectors, ordered {PC_Stall, IF_ID_Stall, IF_ID_Flush,
  // ID_EXE_Stall, ID_EXE_Flush, EXE_MEM_Stall, EXE_MEM_Flush, MEM_WB_Flush,
  // div_start, div_busy}.
  localparam logic [9:0] E_NONE       = 10'b00000000_00;
  localparam logic [9:0] E_FLUSH      = 10'b00101011_00;
  localparam logic [9:0] E_FLUSH_BUSY = 10'b00101011_01;
  localparam logic [9:0] E_DMEM       = 10'b11010101_00;
  localparam logic [9:0] E_DMEM_BUSY  = 10'b11010101_01;
  localparam logic [9:0] E_DIV        = 10'b11010010_01;
  localparam logic [9:0] E_DIV_START  = 10'b11010010_11;
  localparam logic [9:0] E_LU         = 10'b11001000_00;
  localparam logic [9:0] E_IMEM       = 10'b10100000_00;

  typedef struct packed {
    logic       rst;
    logic       exc;
    logic       dmem;
    logic       imem;
    logic       is_div;
    logic       load;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       exe_is_div = 1'b0;
  logic       exe_load_wreg = 1'b0;
  logic [4:0] exe_rd = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_use_rs = 1'b0;
  logic       id_use_rt = 1'b0;
  logic       imem_stall = 1'b0;
  logic       dmem_stall = 1'b0;
  logic       exc_valid = 1'b0;
  logic PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EXE_Stall, ID_EXE_Flush;
  logic EXE_MEM_Stall, EXE_MEM_Flush, MEM_WB_Flush, div_start, div_busy;

  logic [9:0] observed;
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .DIV_CYCLES(DIV_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_is_div   (exe_is_div),
    .exe_load_wreg(exe_load_wreg),
    .exe_rd       (exe_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .imem_stall   (imem_stall),
    .dmem_stall   (dmem_stall),
    .exc_valid    (exc_valid),
    .PC_Stall     (PC_Stall),
    .IF_ID_Stall  (IF_ID_Stall),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EXE_Stall (ID_EXE_Stall),
    .ID_EXE_Flush (ID_EXE_Flush),
    .EXE_MEM_Stall(EXE_MEM_Stall),
    .EXE_MEM_Flush(EXE_MEM_Flush),
    .MEM_WB_Flush (MEM_WB_Flush),
    .div_start    (div_start),
    .div_busy     (div_busy)
  );

  assign observed = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EXE_Stall,
                     ID_EXE_Flush, EXE_MEM_Stall, EXE_MEM_Flush,
                     MEM_WB_Flush, div_start, div_busy};

  // Drive one cycle of inputs at the falling edge and queue its expectation.
  task automatic apply_stimulus(input stim_t s, input logic [9:0] expected);
    @(negedge clk);
    rst           = s.rst;
    exc_valid     = s.exc;
    dmem_stall    = s.dmem;
    imem_stall    = s.imem;
    exe_is_div    = s.is_div;
    exe_load_wreg = s.load;
    exe_rd        = s.rd;
    id_rs         = s.rs;
    id_rt         = s.rt;
    id_use_rs     = s.use_rs;
    id_use_rt     = s.use_rt;
    exp_q.push_back(expected);
  endtask

  task automatic check_output(input string tag);
    logic [9:0] expected;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: no queued expectation, observed %b", tag, observed);
    end else begin
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
    end
  endtask

  task automatic step(input stim_t s, input logic [9:0] expected, input string tag);
    apply_stimulus(s, expected);
    check_output(tag);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    stim_t s;

    s = '0;
    s.rst = 1'b1;
    step(s, E_FLUSH, "reset");
    s.is_div = 1'b1; s.load = 1'b1; s.rd = 5'd5; s.rs = 5'd5; s.use_rs = 1'b1;
    step(s, E_FLUSH, "reset_overrides_causes");

    s = '0;
    step(s, E_NONE, "idle");

    s.load = 1'b1; s.rd = 5'd5; s.rs = 5'd5; s.use_rs = 1'b1;
    step(s, E_LU, "load_use_rs");
    s.rd = 5'd0; s.rs = 5'd0;
    step(s, E_NONE, "load_use_rd_zero");
    s.rd = 5'd5; s.rs = 5'd6;
    step(s, E_NONE, "load_use_rs_mismatch");

    s = '0;
    s.load = 1'b1; s.rd = 5'd7; s.rt = 5'd7; s.use_rt = 1'b1;
    step(s, E_LU, "load_use_rt");
    s.use_rt = 1'b0;
    step(s, E_NONE, "load_use_rt_unused");
    s.use_rt = 1'b1; s.load = 1'b0;
    step(s, E_NONE, "no_load_no_hazard");

    s = '0;
    s.imem = 1'b1;
    step(s, E_IMEM, "imem_only");
    s.load = 1'b1; s.rd = 5'd9; s.rs = 5'd9; s.use_rs = 1'b1;
    step(s, E_LU, "load_use_over_imem");
    s.dmem = 1'b1;
    step(s, E_DMEM, "dmem_over_load_use");
    s.exc = 1'b1;
    step(s, E_FLUSH, "exc_over_dmem");

`ifdef PIPE_CTRL_DIV_EN
    // Full divide with an instruction-fetch stall masked underneath.
    s = '0;
    s.is_div = 1'b1;
    step(s, E_DIV_START, "div1_start");
    s.imem = 1'b1;
    for (int k = 1; k <= DIV_N; k++) step(s, E_DIV, $sformatf("div1_wait_%0d", k));
    // DIV_DONE ignores a new divide; the next one starts from RUN.
    s.imem = 1'b0;
    step(s, E_NONE, "div1_done");
    step(s, E_DIV_START, "div2_start_back_to_back");

    // Exception in the middle of the count aborts the divide.
    for (int k = 1; k <= 22; k++) step(s, E_DIV, $sformatf("div2_wait_%0d", k));
    s.exc = 1'b1;
    step(s, E_FLUSH_BUSY, "div2_exc_flush");
    s = '0;
    step(s, E_NONE, "div2_after_exc_idle");

    // Memory stall early in the count must not freeze the counter.
    s.is_div = 1'b1;
    step(s, E_DIV_START, "div3_start_after_exc");
    s.dmem = 1'b1;
    for (int k = 1; k <= 3; k++) step(s, E_DMEM_BUSY, $sformatf("div3_dmem_wait_%0d", k));
    s.dmem = 1'b0;
    for (int k = 4; k <= DIV_N; k++) step(s, E_DIV, $sformatf("div3_wait_%0d", k));
    s.dmem = 1'b1;
    for (int k = 1; k <= 3; k++) step(s, E_DMEM, $sformatf("div3_done_hold_%0d", k));
    s.dmem = 1'b0;
    step(s, E_NONE, "div3_done_release");
    step(s, E_DIV_START, "div4_start");

    // Reset mid-divide abandons it without a new start pulse.
    for (int k = 1; k <= 5; k++) step(s, E_DIV, $sformatf("div4_wait_%0d", k));
    s.rst = 1'b1;
    step(s, E_FLUSH, "div4_reset");
    s = '0;
    step(s, E_NONE, "div4_after_reset_idle");
`else
    s = '0;
    s.is_div = 1'b1;
    step(s, E_NONE, "div_disabled_ignored");
    s.imem = 1'b1;
    step(s, E_IMEM, "div_disabled_imem");
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
